// File: rtl/param_readback.sv
// param_readback: streams a snapshot of the amplitude, offset and phase-word
// banks back to the host as one framed sequence of W-bit words.
// Frame layout: HEADER, amps[0..NBLK-1], offsets[0..NBLK-1],
// phasewords[0..NBLK-1], checksum (wrap-around sum of the data words).
// dout is first-word-fall-through: the word shown is the one a read consumes.
module param_readback #(
  parameter int              NBLK   = 64,
  parameter int              W      = 16,
  parameter logic [W-1:0]    HEADER = 16'hA5C3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [NBLK*W-1:0] amps,
  input  logic [NBLK*W-1:0] offsets,
  input  logic [NBLK*W-1:0] phasewords,
  input  logic              rd_en,
  output logic [W-1:0]      dout,
  output logic              busy,
  output logic              done,
  output logic              underrun
);

  localparam int NDATA  = 3 * NBLK;
  localparam int NWORDS = NDATA + 2;
  localparam int IW     = $clog2(NWORDS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NWORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [W-1:0]    acc_q, acc_d;
  logic            underrun_q, underrun_d;
  logic            load;
  logic [W-1:0]    cur_word;

  // Snapshot storage: amps at 0..NBLK-1, offsets next, phase words last, so
  // frame index i (1..NDATA) maps directly to entry i-1.
  logic [W-1:0]    snap_q [NDATA];

  // Capture all three banks on an accepted start; frozen for the whole frame.
  always_ff @(posedge clk) begin
    if (load) begin
      for (int k = 0; k < NBLK; k++) begin
        snap_q[k]          <= amps[W*k +: W];
        snap_q[NBLK + k]   <= offsets[W*k +: W];
        snap_q[2*NBLK + k] <= phasewords[W*k +: W];
      end
    end
  end

  // Select the word at the current frame index (header, data or checksum).
  always_comb begin
    cur_word = '0;
    if (idx_q == '0) begin
      cur_word = HEADER;
    end else if (idx_q == LAST_IDX) begin
      cur_word = acc_q;
    end else begin
      cur_word = snap_q[idx_q - IW'(1)];
    end
  end

  // Control state, frame index, running checksum and sticky underrun flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      acc_q      <= '0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      acc_q      <= acc_d;
      underrun_q <= underrun_d;
    end
  end

  // Next-state and output decode. The checksum accumulates each data word as
  // it is consumed, so it is ready the cycle the final data word is read.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    acc_d      = acc_q;
    underrun_d = underrun_q;
    load       = 1'b0;
    dout       = '0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (rd_en) begin
          underrun_d = 1'b1;
        end
        if (start) begin
          load       = 1'b1;
          idx_d      = '0;
          acc_d      = '0;
          // A read in the same cycle as start still counts as an underrun.
          underrun_d = rd_en;
          state_d    = S_SEND;
        end
      end
      S_SEND: begin
        busy = 1'b1;
        dout = cur_word;
        if (rd_en) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + IW'(1);
            if (idx_q != '0) begin
              acc_d = acc_q + cur_word;
            end
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        // Not busy here, so a read is an underrun just as in idle.
        if (rd_en) begin
          underrun_d = 1'b1;
        end
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign underrun = underrun_q;

endmodule

// File: tb/tb_param_readback.sv
// Testbench for param_readback: random and directed bank contents, a frame
// model built from plain arrays, and per-scenario tasks with inline checks.
module tb_param_readback;

  localparam int NBLK   = 64;
  localparam int W      = 16;
  localparam int NWORDS = 3 * NBLK + 2;
  localparam logic [15:0] HDR = 16'hA5C3;

  logic              clk;
  logic              reset_n;
  logic              start;
  logic [NBLK*W-1:0] amps;
  logic [NBLK*W-1:0] offsets;
  logic [NBLK*W-1:0] phasewords;
  logic              rd_en;
  logic [W-1:0]      dout;
  logic              busy;
  logic              done;
  logic              underrun;

  int vectors;
  int miscompares;

  logic [15:0] ba [NBLK];
  logic [15:0] bo [NBLK];
  logic [15:0] bp [NBLK];
  logic [15:0] exp_frame [NWORDS];
  logic [15:0] got_q [$];
  int          done_cyc;

  param_readback #(.NBLK(NBLK), .W(W), .HEADER(16'hA5C3)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .amps       (amps),
    .offsets    (offsets),
    .phasewords (phasewords),
    .rd_en      (rd_en),
    .dout       (dout),
    .busy       (busy),
    .done       (done),
    .underrun   (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive the bank vectors from the model arrays and build the expected frame.
  task automatic load_banks;
    int sum;
    sum = 0;
    for (int k = 0; k < NBLK; k++) begin
      amps[W*k +: W]       = ba[k];
      offsets[W*k +: W]    = bo[k];
      phasewords[W*k +: W] = bp[k];
    end
    exp_frame[0] = HDR;
    for (int k = 0; k < NBLK; k++) begin
      exp_frame[1 + k]          = ba[k];
      exp_frame[1 + NBLK + k]   = bo[k];
      exp_frame[1 + 2*NBLK + k] = bp[k];
    end
    for (int i = 1; i <= 3 * NBLK; i++) sum += int'(exp_frame[i]);
    exp_frame[NWORDS-1] = 16'(sum % 65536);
  endtask

  task automatic random_banks;
    for (int k = 0; k < NBLK; k++) begin
      ba[k] = 16'($urandom_range(0, 65535));
      bo[k] = 16'($urandom_range(0, 65535));
      bp[k] = 16'($urandom_range(0, 65535));
    end
    load_banks();
  endtask

  // Start a frame and read it out, collecting each consumed word into got_q.
  // gap_max: random idle cycles between reads; restart_at: word index at which
  // a second start is raised (-1 for none); clobber: overwrite banks after start.
  task automatic stream_frame(input int gap_max, input int restart_at, input bit clobber);
    int cyc;
    int gap;
    got_q.delete();
    done_cyc = -1;
    gap = 0;
    @(negedge clk);
    start = 1'b1;
    rd_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    if (clobber) begin
      amps       = '1;
      offsets    = '1;
      phasewords = '1;
    end
    cyc = 0;
    while (cyc < 3000 && done_cyc < 0) begin
      start = 1'b0;
      if (done) begin
        done_cyc = cyc;
        rd_en = 1'b0;
      end else if (busy) begin
        if (gap > 0) begin
          rd_en = 1'b0;
          gap--;
        end else begin
          rd_en = 1'b1;
          got_q.push_back(dout);
          gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
          if (restart_at >= 0 && got_q.size() == restart_at + 1) start = 1'b1;
        end
      end else begin
        rd_en = 1'b0;
      end
      if (done_cyc < 0) begin
        @(posedge clk);
        cyc++;
        @(negedge clk);
      end
    end
    rd_en = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    #3;
    vectors++;
    if (dout !== 16'h0000) begin miscompares++; $display("FAIL reset_dout got=%h exp=0000", dout); end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", busy); end
    vectors++;
    if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got=%b exp=0", done); end
    vectors++;
    if (underrun !== 1'b0) begin miscompares++; $display("FAIL reset_underrun got=%b exp=0", underrun); end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      vectors++;
      if ({dout, busy, done, underrun} !== 19'h0) begin
        miscompares++;
        $display("FAIL idle_after_reset cyc=%0d got dout=%h busy=%b done=%b underrun=%b exp all 0",
                 c, dout, busy, done, underrun);
      end
    end
    $display("test_reset: reset and 10 idle cycles checked");
  endtask

  task automatic test_full_frame;
    for (int k = 0; k < NBLK; k++) begin
      ba[k] = 16'(k);
      bo[k] = 16'(16'h0100 + k);
      bp[k] = 16'(16'h0200 + k);
    end
    load_banks();
    stream_frame(0, -1, 1'b0);
    vectors++;
    if (got_q.size() != NWORDS) begin
      miscompares++; $display("FAIL full_len got=%0d exp=%0d", got_q.size(), NWORDS);
    end
    for (int i = 0; i < NWORDS && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_frame[i]) begin
        miscompares++; $display("FAIL full_word[%0d] got=%h exp=%h", i, got_q[i], exp_frame[i]);
      end
    end
    if (got_q.size() == NWORDS) begin
      vectors++;
      if (got_q[NWORDS-1] !== 16'hD7A0) begin
        miscompares++; $display("FAIL full_checksum got=%h exp=d7a0", got_q[NWORDS-1]);
      end
    end
    vectors++;
    if (done_cyc != 194) begin
      miscompares++; $display("FAIL full_done_time got=%0d exp=194", done_cyc);
    end
    vectors++;
    if ({busy, dout} !== 17'h0) begin
      miscompares++; $display("FAIL done_cycle_outputs got busy=%b dout=%h exp 0/0000", busy, dout);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0) begin
      miscompares++; $display("FAIL done_width got=%b exp=0", done);
    end
    $display("test_full_frame: %0d words, done after %0d cycles", got_q.size(), done_cyc);
  endtask

  task automatic test_snapshot_stall;
    for (int rep = 0; rep < 2; rep++) begin
      random_banks();
      stream_frame(5, -1, 1'b1);
      vectors++;
      if (got_q.size() != NWORDS || done_cyc < 0) begin
        miscompares++;
        $display("FAIL snap_len rep=%0d got=%0d done_cyc=%0d exp=%0d", rep, got_q.size(), done_cyc, NWORDS);
      end
      for (int i = 0; i < NWORDS && i < got_q.size(); i++) begin
        vectors++;
        if (got_q[i] !== exp_frame[i]) begin
          miscompares++;
          $display("FAIL snap_word[%0d] rep=%0d got=%h exp=%h", i, rep, got_q[i], exp_frame[i]);
        end
      end
      $display("test_snapshot_stall: rep %0d, %0d words in %0d cycles", rep, got_q.size(), done_cyc);
    end
  endtask

  task automatic test_checksum_wrap;
    for (int k = 0; k < NBLK; k++) begin
      ba[k] = 16'hFFFF;
      bo[k] = 16'hFFFF;
      bp[k] = 16'hFFFF;
    end
    load_banks();
    stream_frame(1, -1, 1'b0);
    vectors++;
    if (got_q.size() != NWORDS) begin
      miscompares++; $display("FAIL wrap_len got=%0d exp=%0d", got_q.size(), NWORDS);
    end else begin
      vectors++;
      if (got_q[NWORDS-1] !== 16'hFF40) begin
        miscompares++; $display("FAIL wrap_checksum got=%h exp=ff40", got_q[NWORDS-1]);
      end
      vectors++;
      if (got_q[NWORDS-1] !== exp_frame[NWORDS-1]) begin
        miscompares++; $display("FAIL wrap_model got=%h exp=%h", got_q[NWORDS-1], exp_frame[NWORDS-1]);
      end
    end
    $display("test_checksum_wrap: checksum word %h", (got_q.size() == NWORDS) ? got_q[NWORDS-1] : 16'h0);
  endtask

  task automatic test_underrun_idle;
    @(negedge clk);
    vectors++;
    if (underrun !== 1'b0) begin miscompares++; $display("FAIL underrun_pre got=%b exp=0", underrun); end
    rd_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rd_en = 1'b0;
    vectors++;
    if (underrun !== 1'b1) begin miscompares++; $display("FAIL underrun_set got=%b exp=1", underrun); end
    vectors++;
    if ({busy, dout} !== 17'h0) begin
      miscompares++; $display("FAIL underrun_idle_out got busy=%b dout=%h exp 0/0000", busy, dout);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (underrun !== 1'b1) begin miscompares++; $display("FAIL underrun_sticky got=%b exp=1", underrun); end
    $display("test_underrun_idle: underrun=%b", underrun);
  endtask

  task automatic test_restart_ignored;
    random_banks();
    stream_frame(2, 40, 1'b0);
    vectors++;
    if (got_q.size() != NWORDS || done_cyc < 0) begin
      miscompares++; $display("FAIL restart_len got=%0d exp=%0d", got_q.size(), NWORDS);
    end
    for (int i = 0; i < NWORDS && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_frame[i]) begin
        miscompares++; $display("FAIL restart_word[%0d] got=%h exp=%h", i, got_q[i], exp_frame[i]);
      end
    end
    vectors++;
    if (underrun !== 1'b0) begin miscompares++; $display("FAIL underrun_cleared got=%b exp=0", underrun); end
    $display("test_restart_ignored: %0d words, underrun=%b", got_q.size(), underrun);
  endtask

  task automatic test_start_with_read;
    int n;
    random_banks();
    @(negedge clk);
    start = 1'b1;
    rd_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    rd_en = 1'b0;
    vectors++;
    if ({busy, dout, underrun} !== {1'b1, HDR, 1'b1}) begin
      miscompares++;
      $display("FAIL start_rd_same got busy=%b dout=%h underrun=%b exp 1/%h/1", busy, dout, underrun, HDR);
    end
    n = 0;
    for (int c = 0; c < 400 && busy; c++) begin
      vectors++;
      if (n < NWORDS && dout !== exp_frame[n]) begin
        miscompares++; $display("FAIL start_rd_word[%0d] got=%h exp=%h", n, dout, exp_frame[n]);
      end
      rd_en = 1'b1;
      n++;
      @(posedge clk);
      @(negedge clk);
      rd_en = 1'b0;
    end
    vectors++;
    if (done !== 1'b1 || n != NWORDS) begin
      miscompares++; $display("FAIL start_rd_end got done=%b words=%0d exp 1/%0d", done, n, NWORDS);
    end
    $display("test_start_with_read: %0d words read", n);
  endtask

  task automatic test_reset_mid_frame;
    random_banks();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    rd_en = 1'b1;
    repeat (50) @(posedge clk);
    @(negedge clk);
    rd_en = 1'b0;
    vectors++;
    if (dout !== exp_frame[50]) begin
      miscompares++; $display("FAIL mid_word50 got=%h exp=%h", dout, exp_frame[50]);
    end
    #2 reset_n = 1'b0;
    #1;
    vectors++;
    if ({busy, dout, done, underrun} !== 19'h0) begin
      miscompares++;
      $display("FAIL mid_reset got busy=%b dout=%h done=%b underrun=%b exp all 0", busy, dout, done, underrun);
    end
    @(negedge clk);
    reset_n = 1'b1;
    random_banks();
    stream_frame(1, -1, 1'b0);
    vectors++;
    if (got_q.size() != NWORDS || done_cyc < 0) begin
      miscompares++; $display("FAIL post_reset_len got=%0d exp=%0d", got_q.size(), NWORDS);
    end
    for (int i = 0; i < NWORDS && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_frame[i]) begin
        miscompares++; $display("FAIL post_reset_word[%0d] got=%h exp=%h", i, got_q[i], exp_frame[i]);
      end
    end
    $display("test_reset_mid_frame: %0d words after reset", got_q.size());
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset_n     = 1'b0;
    start       = 1'b0;
    rd_en       = 1'b0;
    amps        = '0;
    offsets     = '0;
    phasewords  = '0;
    test_reset();
    test_full_frame();
    test_snapshot_stall();
    test_checksum_wrap();
    test_underrun_idle();
    test_restart_ignored();
    test_start_with_read();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/param_readback.md
# param_readback

Serialises the three 1024-bit waveform parameter banks (amplitudes, offsets, phase words; 64 blocks × 16 bits each) back to the host as a framed stream of 16-bit words, read through a pipe-out endpoint. It is the transmit counterpart of the per-block parameter combiners on the pipe-in side, and lets host software confirm exactly what the 64-block generator is running. It sits in the `ti_clk` domain, between the active parameter registers and an `okPipeOut` (`ep_read` → `rd_en`, `ep_datain` ← `dout`).

## Interface
Parameters:
- `NBLK`, 64, number of generator blocks per bank.
- `W`, 16, word width; must equal the pipe width.
- `HEADER`, 16'hA5C3, frame start word.

Ports:
- `clk`  in  1  host interface clock (`ti_clk`); only clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to snapshot the banks and begin a frame.
- `amps`  in  NBLK*W  amplitude bank; block k at bits [W*k+W-1 : W*k].
- `offsets`  in  NBLK*W  offset bank; same mapping.
- `phasewords`  in  NBLK*W  phase-word bank; same mapping.
- `rd_en`  in  1  pipe-out read strobe; consumes the current word.
- `dout`  out  W  current word, first-word-fall-through.
- `busy`  out  1  frame in progress.
- `done`  out  1  one-cycle pulse when the last word is consumed.
- `underrun`  out  1  sticky flag: `rd_en` seen while not busy.

## Operation
- Frame is 2 + 3·NBLK words (194 by default), in this order:
  - index 0: `HEADER`.
  - indices 1..64: amps blocks 0..63.
  - indices 65..128: offsets blocks 0..63.
  - indices 129..192: phasewords blocks 0..63.
  - index 193: checksum, the 16-bit wrap-around sum of words 1..192 (header excluded).
- State machine:
  - IDLE: `dout`=0, `busy`=0.
    - `start` → copy all three banks into internal snapshot registers, clear the index and checksum accumulator, go to SEND.
  - SEND: `dout` = word[index].
    - `rd_en` on a data word (index 1..192) → add that word to the accumulator, then index+1.
    - `rd_en` on index 0 → index+1 only.
    - `rd_en` on the checksum word → go to DONE.
  - DONE: `done`=1 for exactly this one cycle, then IDLE unconditionally.
- Snapshot isolation: changes to `amps`, `offsets` or `phasewords` after the `start` edge never affect the frame in progress.
- `start` while in SEND or DONE is ignored. No restart, no flag.
- `rd_en` while in IDLE: `dout` stays 0, the index does not move, and `underrun` is set to 1. `underrun` is cleared only by reset or by an accepted `start`.
- `start` and `rd_en` in the same IDLE cycle: `start` is accepted, the read is treated as an underrun, and `underrun` ends at 1.
- `rd_en` low in SEND: hold the current word and index indefinitely. There is no timeout.
- Arithmetic: the checksum accumulator is W bits and discards carries.

## Timing
- Reset (async assert, release synchronised to `clk`):
  - state IDLE, index 0, accumulator 0.
  - `dout`=0, `busy`=0, `done`=0, `underrun`=0.
- `start` sampled high at edge N → from edge N onward `busy`=1 and `dout`=`HEADER`.
- Each `rd_en` sampled high at an edge in SEND → the next word appears on `dout` after that same edge (zero-wait streaming, one word per cycle).
- The checksum word is valid on `dout` immediately after the edge that consumed word 192.
  - The accumulator is registered; no combinational 192-word adder.
- `rd_en` at edge M on the checksum word → after M: `done`=1, `busy`=0, `dout`=0. After M+1: `done`=0.
- Minimum frame time with `rd_en` held high: 194 cycles from the start edge to the `done` pulse.
- `reset_n` low mid-frame → outputs return to reset values immediately (async). The next `start` begins again at the header.

## Test plan
- Reset check: hold `reset_n` low → `dout`=0, `busy`=0, `done`=0, `underrun`=0. Release and idle for 10 cycles → all outputs unchanged.
- Full frame, `rd_en` held high:
  - Stimulus: amps[k]=k, offsets[k]=16'h0100+k, phasewords[k]=16'h0200+k.
  - Required: words 0x A5C3, 0x0000..0x003F, 0x0100..0x013F, 0x0200..0x023F, then checksum 16'hD7A0.
  - `done` pulses exactly 194 cycles after `start`.
- Snapshot and stall:
  - Stimulus: after `start`, set every input bank word to 16'hFFFF, and insert random `rd_en` gaps of 0–5 cycles.
  - Required: the output sequence is identical to the original frame, and no word is repeated or skipped.
- Checksum wrap: all bank words 16'hFFFF → checksum 16'hFF40.
- Protocol abuse:
  - `rd_en` pulsed in IDLE → `underrun`=1 and `dout` stays 0.
  - A second `start` at word 40 → ignored, frame continues.
  - `start` after `done` → `underrun` clears to 0.
- Reset mid-frame: assert `reset_n` low while word 50 is on `dout` → `busy`=0 and `dout`=0 immediately. Next `start` → header first, with a correct checksum.
